// File: rtl/video_mode_switch_ctrl_if.sv
// -----------------------------------------------------------------------------
// video_mode_switch_ctrl_if
// Mode-change request handshake between the control/UART config path and the
// video mode switch controller. A transfer happens on a clock edge where
// req_valid and req_ready are both high; the requester keeps req_valid and
// req_mode stable until that edge.
//   req_valid  requester -> controller   mode-change request
//   req_mode   requester -> controller   requested mode index (0..3)
//   req_ready  controller -> requester   controller can take a request
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface video_mode_switch_ctrl_if;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;

  modport master (output req_valid, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_mode, output req_ready);
endinterface

// File: rtl/video_mode_switch_ctrl.sv
// -----------------------------------------------------------------------------
// video_mode_switch_ctrl
// Run-time resolution controller for the HDMI video timing generator. Keeps a
// four-entry table of CEA/VESA timing sets and drives the generator's timing
// inputs. A mode change waits for the next rising edge of the generator's
// vsync. The new timing set is then loaded while the generator is held in
// reset for HOLD_CYCLES clocks, so no partial frame reaches HDMI.
//
// Ports
//   clk, rstn        pixel clock; synchronous active-low reset
//   req_if (slave)   req_valid / req_mode / req_ready request handshake
//   tg_vs            vs_out of the timing generator (active high)
//   tg_rstn          synchronous active-low reset to the timing generator
//   h_* / v_*        horizontal / vertical timing of the current mode
//   cur_mode         mode currently driven
//   busy             switch in progress (waiting for vsync or holding reset)
//   done             one-cycle pulse when a request completes
//   timeout_flag     sticky: a switch was forced by the vsync timeout
//
// Configuration
//   VMODE_TIMEOUT_EN  when defined, a 24-bit wait counter forces the switch
//                     after TIMEOUT_CYCLES clocks without a vsync edge, and
//                     sets timeout_flag. When undefined, the controller waits
//                     for vsync indefinitely and timeout_flag is tied low.
// -----------------------------------------------------------------------------
module video_mode_switch_ctrl #(
  parameter int          X_BITS         = 12,
  parameter int          Y_BITS         = 12,
  parameter logic [1:0]  DEFAULT_MODE   = 2'd0,
  parameter logic [7:0]  HOLD_CYCLES    = 8'd16,   // legal range 1..255
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic                    clk,
  input  logic                    rstn,
  video_mode_switch_ctrl_if.slave req_if,
  input  logic                    tg_vs,
  output logic                    tg_rstn,
  output logic [X_BITS-1:0]       h_total,
  output logic [X_BITS-1:0]       h_fp,
  output logic [X_BITS-1:0]       h_bp,
  output logic [X_BITS-1:0]       h_sync,
  output logic [X_BITS-1:0]       h_act,
  output logic [Y_BITS-1:0]       v_total,
  output logic [Y_BITS-1:0]       v_fp,
  output logic [Y_BITS-1:0]       v_bp,
  output logic [Y_BITS-1:0]       v_sync,
  output logic [Y_BITS-1:0]       v_act,
  output logic [1:0]              cur_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_flag
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, HOLD} state_t;

  typedef struct packed {
    logic [X_BITS-1:0] h_total, h_fp, h_bp, h_sync, h_act;
    logic [Y_BITS-1:0] v_total, v_fp, v_bp, v_sync, v_act;
  } timing_t;

  // The mode table is a constant decode, not a storage array.
  function automatic timing_t mode_entry(input logic [1:0] m);
    int      h [5];
    int      v [5];
    timing_t t;
    case (m)
      2'd0:    begin h = '{1650, 110, 220,  40, 1280}; v = '{ 750, 5, 20, 5,  720}; end
      2'd1:    begin h = '{2200,  88, 148,  44, 1920}; v = '{1125, 4, 36, 5, 1080}; end
      2'd2:    begin h = '{ 800,  16,  48,  96,  640}; v = '{ 525,10, 33, 2,  480}; end
      default: begin h = '{1344,  24, 160, 136, 1024}; v = '{ 806, 3, 29, 6,  768}; end
    endcase
    t.h_total = X_BITS'(h[0]);
    t.h_fp    = X_BITS'(h[1]);
    t.h_bp    = X_BITS'(h[2]);
    t.h_sync  = X_BITS'(h[3]);
    t.h_act   = X_BITS'(h[4]);
    t.v_total = Y_BITS'(v[0]);
    t.v_fp    = Y_BITS'(v[1]);
    t.v_bp    = Y_BITS'(v[2]);
    t.v_sync  = Y_BITS'(v[3]);
    t.v_act   = Y_BITS'(v[4]);
    return t;
  endfunction

  state_t     state_q,     state_d;
  timing_t    tim_q,       tim_d;
  logic       tg_rstn_q,   tg_rstn_d;
  logic [1:0] cur_mode_q,  cur_mode_d;
  logic [1:0] tgt_mode_q,  tgt_mode_d;   // mode latched at request acceptance
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;
  logic       req_ready_q, req_ready_d;
  logic       vs_dly_q,    vs_dly_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;
  logic       vs_rise;

  assign vs_dly_d = tg_vs;
  assign vs_rise  = tg_vs & ~vs_dly_q;

`ifdef VMODE_TIMEOUT_EN
  logic [23:0] wait_cnt_q,     wait_cnt_d;
  logic        timeout_flag_q, timeout_flag_d;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt_q == TIMEOUT_CYCLES - 24'd1);
`endif

  always_comb begin
    // NOTE: every _d takes its hold value before the case, so no branch can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    tim_d      = tim_q;
    tg_rstn_d  = tg_rstn_q;
    cur_mode_d = cur_mode_q;
    tgt_mode_d = tgt_mode_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
`ifdef VMODE_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    timeout_flag_d = timeout_flag_q;
`endif

    case (state_q)
      IDLE: begin
        tg_rstn_d = 1'b1;
        if (req_if.req_valid && req_ready_q) begin
          if (req_if.req_mode == cur_mode_q) begin
            // Already in the requested mode: acknowledge without a reset pulse.
            done_d = 1'b1;
          end else begin
            tgt_mode_d = req_if.req_mode;
            state_d    = WAIT_VS;
`ifdef VMODE_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end

      WAIT_VS: begin
        // Only rising edges seen while in this state count; vs_dly_q keeps
        // tracking tg_vs in every state, so an older edge cannot leak in.
`ifdef VMODE_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 24'd1;
        if (vs_rise || timeout_hit) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          if (!vs_rise) timeout_flag_d = 1'b1;
        end
`else
        if (vs_rise) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
`endif
      end

      HOLD: begin
        // First HOLD edge drops tg_rstn and loads the new table entry together,
        // so the timing outputs never move while the generator is running.
        if (hold_cnt_q == 8'd0) begin
          tg_rstn_d  = 1'b0;
          tim_d      = mode_entry(tgt_mode_q);
          hold_cnt_d = 8'd1;
        end else if (hold_cnt_q == HOLD_CYCLES) begin
          tg_rstn_d  = 1'b1;
          cur_mode_d = tgt_mode_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next state.
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (!rstn) begin
      state_q     <= IDLE;
      tim_q       <= mode_entry(DEFAULT_MODE);
      tg_rstn_q   <= 1'b0;
      cur_mode_q  <= DEFAULT_MODE;
      tgt_mode_q  <= DEFAULT_MODE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
      vs_dly_q    <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tim_q       <= tim_d;
      tg_rstn_q   <= tg_rstn_d;
      cur_mode_q  <= cur_mode_d;
      tgt_mode_q  <= tgt_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      vs_dly_q    <= vs_dly_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

`ifdef VMODE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

  assign req_if.req_ready = req_ready_q;
  assign tg_rstn          = tg_rstn_q;
  assign cur_mode         = cur_mode_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign h_total          = tim_q.h_total;
  assign h_fp             = tim_q.h_fp;
  assign h_bp             = tim_q.h_bp;
  assign h_sync           = tim_q.h_sync;
  assign h_act            = tim_q.h_act;
  assign v_total          = tim_q.v_total;
  assign v_fp             = tim_q.v_fp;
  assign v_bp             = tim_q.v_bp;
  assign v_sync           = tim_q.v_sync;
  assign v_act            = tim_q.v_act;

endmodule

// File: tb/tb_video_mode_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_mode_switch_ctrl
// Self-checking bench for video_mode_switch_ctrl. A schedule-based reference
// model (which table row is on the outputs, when the generator reset window
// opens and closes) is compared against every DUT output on each falling
// clock edge. Directed sequences pin the model with literal values, and a
// randomized phase then exercises requests, vsync edges and resets.
// -----------------------------------------------------------------------------
module tb_video_mode_switch_ctrl;

  localparam int HOLD = 16;
`ifdef VMODE_TIMEOUT_EN
  localparam int TO         = 50;
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam int TO         = 2000000;
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        tg_vs = 1'b0;
  logic        tg_rstn, busy, done, timeout_flag;
  logic [1:0]  cur_mode;
  logic [11:0] h_total, h_fp, h_bp, h_sync, h_act;
  logic [11:0] v_total, v_fp, v_bp, v_sync, v_act;

  video_mode_switch_ctrl_if req_if ();

  always #5 clk = ~clk;

  video_mode_switch_ctrl #(
    .X_BITS        (12),
    .Y_BITS        (12),
    .DEFAULT_MODE  (2'd0),
    .HOLD_CYCLES   (8'(HOLD)),
    .TIMEOUT_CYCLES(24'(TO))
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_if      (req_if),
    .tg_vs       (tg_vs),
    .tg_rstn     (tg_rstn),
    .h_total     (h_total),
    .h_fp        (h_fp),
    .h_bp        (h_bp),
    .h_sync      (h_sync),
    .h_act       (h_act),
    .v_total     (v_total),
    .v_fp        (v_fp),
    .v_bp        (v_bp),
    .v_sync      (v_sync),
    .v_act       (v_act),
    .cur_mode    (cur_mode),
    .busy        (busy),
    .done        (done),
    .timeout_flag(timeout_flag)
  );

  // Timing table: H total/fp/bp/sync/act and V total/fp/bp/sync/act.
  int tbl_h [4][5] = '{'{1650,110,220,40,1280}, '{2200,88,148,44,1920},
                       '{800,16,48,96,640},     '{1344,24,160,136,1024}};
  int tbl_v [4][5] = '{'{750,5,20,5,720},  '{1125,4,36,5,1080},
                       '{525,10,33,2,480}, '{806,3,29,6,768}};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a switch is a scheduled window [sw_edge, rel_edge) in
  // edge numbers, during which the generator is held in reset.
  // ---------------------------------------------------------------------------
  longint n_edge   = 0;
  longint acc_edge = 0;
  longint sw_edge  = -1;
  longint rel_edge = -1;
  int     m_tim    = 0;   // table row on the timing outputs
  int     m_cur    = 0;
  int     m_tgt    = 0;
  bit     m_tg     = 0;
  bit     m_busy   = 0;
  bit     m_done   = 0;
  bit     m_flag   = 0;
  bit     m_vs_d   = 0;
  bit     m_valid  = 0;

  always @(posedge clk) begin : model
    bit vs_rise;
    bit forced;
    n_edge++;
    m_valid = 1'b1;
    if (!rstn) begin
      m_tim = 0; m_cur = 0; m_tgt = 0; m_tg = 0; m_busy = 0;
      m_done = 0; m_flag = 0; sw_edge = -1; rel_edge = -1;
    end else begin
      vs_rise = tg_vs && !m_vs_d;
      m_done  = 0;
      if (sw_edge >= 0) begin
        if (n_edge == sw_edge) begin m_tim = m_tgt; m_tg = 0; end
        if (n_edge == rel_edge) begin
          m_tg = 1; m_cur = m_tgt; m_done = 1; m_busy = 0; sw_edge = -1;
        end
      end else if (m_busy) begin
        forced = TIMEOUT_EN && (n_edge - acc_edge == longint'(TO));
        if (vs_rise || forced) begin
          sw_edge  = n_edge + 1;
          rel_edge = n_edge + 1 + HOLD;
          if (!vs_rise) m_flag = 1;
        end
      end else begin
        m_tg = 1;
        if (req_if.req_valid) begin
          if (int'(req_if.req_mode) == m_cur) m_done = 1;
          else begin m_tgt = int'(req_if.req_mode); m_busy = 1; acc_edge = n_edge; end
        end
      end
    end
    m_vs_d = rstn ? tg_vs : 1'b0;
  end

  // One compare process, every falling edge once the model is live.
  always @(negedge clk) begin
    if (m_valid) begin
      check("tg_rstn",      32'(tg_rstn),      32'(m_tg));
      check("cur_mode",     32'(cur_mode),     32'(m_cur));
      check("busy",         32'(busy),         32'(m_busy));
      check("done",         32'(done),         32'(m_done));
      check("req_ready",    32'(req_if.req_ready), 32'(!m_busy));
      check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
      check("h_total", 32'(h_total), tbl_h[m_tim][0]);
      check("h_fp",    32'(h_fp),    tbl_h[m_tim][1]);
      check("h_bp",    32'(h_bp),    tbl_h[m_tim][2]);
      check("h_sync",  32'(h_sync),  tbl_h[m_tim][3]);
      check("h_act",   32'(h_act),   tbl_h[m_tim][4]);
      check("v_total", 32'(v_total), tbl_v[m_tim][0]);
      check("v_fp",    32'(v_fp),    tbl_v[m_tim][1]);
      check("v_bp",    32'(v_bp),    tbl_v[m_tim][2]);
      check("v_sync",  32'(v_sync),  tbl_v[m_tim][3]);
      check("v_act",   32'(v_act),   tbl_v[m_tim][4]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_req(input int mode);
    bit acc;
    req_if.req_valid = 1'b1;
    req_if.req_mode  = 2'(mode);
    for (int i = 0; i < 2000; i++) begin
      acc = (req_if.req_ready === 1'b1);
      @(negedge clk);
      if (acc) begin
        req_if.req_valid = 1'b0;
        return;
      end
    end
    check("req_accept_bound", 32'd0, 32'd1);
    req_if.req_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    tg_vs = 1'b1;
    @(negedge clk);
    tg_vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    check("done_bound", 32'd0, 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int low;
    int done_seen;
    bit acc_prev;
    req_if.req_valid = 1'b0;
    req_if.req_mode  = 2'd0;

    // Reset and release
    repeat (3) @(negedge clk);
    check("rst_tg_rstn", 32'(tg_rstn), 32'd0);
    check("rst_h_total", 32'(h_total), 32'd1650);
    check("rst_v_total", 32'(v_total), 32'd750);
    check("rst_cur_mode", 32'(cur_mode), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_tg_rstn", 32'(tg_rstn), 32'd1);

    // Switch to mode 1 with vsync 100 clocks later
    send_req(1);
    check("sw1_busy", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    tg_vs = 1'b1;
    @(negedge clk);
    tg_vs = 1'b0;
    check("sw1_tg_before", 32'(tg_rstn), 32'd1);
    check("sw1_h_act_before", 32'(h_act), 32'd1650 == 32'd0 ? 32'd0 : 32'd1280);
    @(negedge clk);
    check("sw1_tg_low", 32'(tg_rstn), 32'd0);
    check("sw1_h_act", 32'(h_act), 32'd1920);
    check("sw1_v_total", 32'(v_total), 32'd1125);
    low = 0;
    while (tg_rstn === 1'b0 && low < 300) begin
      low++;
      @(negedge clk);
    end
    check("sw1_low_clocks", low, HOLD);
    check("sw1_done", 32'(done), 32'd1);
    check("sw1_cur_mode", 32'(cur_mode), 32'd1);
    @(negedge clk);
    check("sw1_done_one_cycle", 32'(done), 32'd0);

    // Same-mode request: immediate done, no reset pulse
    send_req(1);
    check("same_done", 32'(done), 32'd1);
    check("same_busy", 32'(busy), 32'd0);
    check("same_tg", 32'(tg_rstn), 32'd1);
    @(negedge clk);
    check("same_done_clear", 32'(done), 32'd0);
    check("same_tg_after", 32'(tg_rstn), 32'd1);

    // Request held during HOLD is accepted only after done
    send_req(0);
    vs_pulse();
    check("held_in_hold", 32'(tg_rstn), 32'd0);
    check("held_ready_low", 32'(req_if.req_ready), 32'd0);
    send_req(2);
    check("held_prev_done", 32'(cur_mode), 32'd0);
    check("held_busy", 32'(busy), 32'd1);
    vs_pulse();
    wait_done(200);
    check("held_h_total", 32'(h_total), 32'd800);
    check("held_v_sync", 32'(v_sync), 32'd2);
    check("held_cur_mode", 32'(cur_mode), 32'd2);
    @(negedge clk);

    // No vsync while waiting for mode 3
    send_req(3);
    repeat (300) @(negedge clk);
`ifdef VMODE_TIMEOUT_EN
    check("to_h_total", 32'(h_total), 32'd1344);
    check("to_flag", 32'(timeout_flag), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
`else
    check("nto_busy", 32'(busy), 32'd1);
    check("nto_h_total", 32'(h_total), 32'd800);
    check("nto_flag", 32'(timeout_flag), 32'd0);
    vs_pulse();
    wait_done(200);
    check("nto_h_total_after", 32'(h_total), 32'd1344);
`endif
    @(negedge clk);

    // Reset asserted in the middle of HOLD
    send_req(1);
    vs_pulse();
    repeat (3) @(negedge clk);
    check("abort_in_hold", 32'(tg_rstn), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_tg", 32'(tg_rstn), 32'd0);
    check("abort_h_total", 32'(h_total), 32'd1650);
    check("abort_cur_mode", 32'(cur_mode), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // Randomized phase
    acc_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) tg_vs = ~tg_vs;
      if (!req_if.req_valid || acc_prev) begin
        req_if.req_valid = ($urandom_range(0, 7) == 0);
        req_if.req_mode  = 2'($urandom_range(0, 3));
      end
      acc_prev = req_if.req_valid && (req_if.req_ready === 1'b1) && rstn;
      @(negedge clk);
    end
    rstn = 1'b1;
    req_if.req_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
